// File: rtl/writeback_mp.sv
// Multi-lane writeback stage with an in-order commit queue.
// Register-file writes leave one cycle after accept; groups retire FIFO.
module writeback_mp #(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int RAW   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [LANES-1:0]        in_is_wb,
  input  logic [LANES*RAW-1:0]    in_wd,
  input  logic [LANES*XLEN-1:0]   in_data,
  input  logic [LANES*64-1:0]     in_pc,
  input  logic [LANES*32-1:0]     in_instr,
  output logic [LANES-1:0]        wb_en,
  output logic [LANES*RAW-1:0]    wb_wd,
  output logic [LANES*XLEN-1:0]   wb_data,
  output logic                    cm_valid,
  input  logic                    cm_ready,
  output logic [LANES-1:0]        cm_lane_valid,
  output logic [LANES-1:0]        cm_is_wb,
  output logic [LANES*RAW-1:0]    cm_wd,
  output logic [LANES*XLEN-1:0]   cm_data,
  output logic [LANES*64-1:0]     cm_pc,
  output logic [LANES*32-1:0]     cm_instr,
  output logic [$clog2(DEPTH):0]  cm_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [LANES-1:0]      qLv   [DEPTH];
  logic [LANES-1:0]      qWb   [DEPTH];
  logic [LANES*RAW-1:0]  qWd   [DEPTH];
  logic [LANES*XLEN-1:0] qData [DEPTH];
  logic [LANES*64-1:0]   qPc   [DEPTH];
  logic [LANES*32-1:0]   qInstr[DEPTH];

  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic [LANES-1:0] wbRaw;
  logic [LANES-1:0] wbMask;

  assign cm_valid = (count != '0);
  assign pop      = cm_valid && cm_ready;
  assign in_ready = (count < FULL) || pop;
  assign push     = in_valid && in_ready;
  assign cm_count = count;

  assign cm_lane_valid = qLv[rdPtr];
  assign cm_is_wb      = qWb[rdPtr];
  assign cm_wd         = qWd[rdPtr];
  assign cm_data       = qData[rdPtr];
  assign cm_pc         = qPc[rdPtr];
  assign cm_instr      = qInstr[rdPtr];

  // Per-lane write intent; a higher lane to the same register wins.
  always_comb begin
    wbRaw  = '0;
    wbMask = '0;
    for (int i = 0; i < LANES; i++) begin
      wbRaw[i] = in_lane_valid[i] && in_is_wb[i] &&
                 (in_wd[i*RAW +: RAW] != '0);
    end
    for (int i = 0; i < LANES; i++) begin
      wbMask[i] = wbRaw[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (wbRaw[j] &&
            in_wd[j*RAW +: RAW] == in_wd[i*RAW +: RAW])
          wbMask[i] = 1'b0;
      end
    end
  end

  // Register-file write port, one cycle after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en   <= '0;
      wb_wd   <= '0;
      wb_data <= '0;
    end else if (push) begin
      wb_en   <= wbMask;
      wb_wd   <= in_wd;
      wb_data <= in_data;
    end else begin
      wb_en   <= '0;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (push) begin
      qLv[wrPtr]    <= in_lane_valid;
      qWb[wrPtr]    <= wbRaw;
      qWd[wrPtr]    <= in_wd;
      qData[wrPtr]  <= in_data;
      qPc[wrPtr]    <= in_pc;
      qInstr[wrPtr] <= in_instr;
    end
  end

endmodule

// File: doc/writeback_mp.md
WRITEBACK_MP -- requirements
Module: writeback_mp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- LANES, 2, instructions retired per group (1..4)
- DEPTH, 4, commit-queue depth in groups (power of 2, >=2)
- XLEN, 64, data width
- RAW, 5, register-address width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM/WB group valid
- in_ready  out  1  group accepted this cycle
- in_lane_valid  in  LANES  per-lane instruction present
- in_is_wb  in  LANES  per-lane writes a register
- in_wd  in  LANES*RAW  per-lane destination
- in_data  in  LANES*XLEN  per-lane result
- in_pc  in  LANES*64  per-lane instruction address
- in_instr  in  LANES*32  per-lane instruction word
- wb_en  out  LANES  register-file write enable
- wb_wd  out  LANES*RAW  register-file address
- wb_data  out  LANES*XLEN  register-file data
- cm_valid  out  1  commit group available
- cm_ready  in  1  commit consumer takes group
- cm_lane_valid, cm_is_wb, cm_wd, cm_data, cm_pc, cm_instr  out  as inputs  commit record
- cm_count  out  $clog2(DEPTH)+1  groups queued

Function
REQ-003 A group SHALL be accepted (acc) when in_valid && in_ready; in_ready SHALL be high when queue count < DEPTH, or count == DEPTH and cm_valid && cm_ready this cycle.
REQ-004 On acc, wb_en[i] SHALL be registered as in_lane_valid[i] && in_is_wb[i] && in_wd[i] != 0, with wb_wd/wb_data registered from the same lane; latency exactly one cycle.
REQ-005 wb_en SHALL be all-zero in every cycle following a cycle without acc; wb_wd/wb_data hold their previous value then.
REQ-006 Lane i SHALL write before lane j>i; when two lanes of one group target the same nonzero wd, the lower lane's wb_en SHALL be cleared so only the highest lane writes.
REQ-007 On acc the group SHALL be pushed into the commit queue with cm_is_wb[i] equal to the wb_en[i] value of REQ-004 before REQ-006 masking, and cm_wd/cm_data equal to that same group's in_wd/in_data (never a prior group's values).
REQ-008 The commit queue SHALL be a FIFO of DEPTH groups with wrapping read/write pointers of $clog2(DEPTH) bits plus a count register.
REQ-009 cm_valid SHALL equal (count != 0); head fields SHALL be stable while cm_valid && !cm_ready.
REQ-010 Pop SHALL occur on cm_valid && cm_ready; simultaneous push and pop SHALL leave count unchanged, including at count == 0 (no bypass: pushed group appears one cycle later) and count == DEPTH.
REQ-011 cm_count SHALL equal count; count SHALL never exceed DEPTH nor underflow; pop at count 0 and push at full without pop SHALL be ignored.
REQ-012 Lanes with in_lane_valid[i]=0 SHALL produce wb_en[i]=0 and cm_lane_valid[i]=0, cm_is_wb[i]=0.
REQ-013 in_valid with all in_lane_valid=0 SHALL still be accepted and pushed as an empty group.

Reset
REQ-014 rst low SHALL asynchronously clear wb_en, wb_wd, wb_data, pointers, count, cm_valid, in_ready-dependent state; in_ready SHALL be 1 while rst is low and after release.
REQ-015 Reset mid-operation SHALL discard all queued groups and any in-flight write; first acc after release SHALL behave as from empty.
REQ-016 Queue payload storage SHALL not require reset.

Verification
REQ-017 Single write: LANES=2, lane0 wd=5 data=0x1234, lane1 invalid -> next cycle wb_en=01, wb_wd[0]=5, wb_data[0]=0x1234; cm_valid next cycle with cm_wd[0]=5, cm_data[0]=0x1234.
REQ-018 x0 and collision: lane0 wd=0 data=7, then group lane0 wd=3 data=1, lane1 wd=3 data=2 -> first gives wb_en=00, cm_is_wb[0]=0; second gives wb_en=10, register 3 written with 2, cm_is_wb=11.
REQ-019 Fill/backpressure: DEPTH=4, cm_ready=0, 5 consecutive valid groups -> in_ready drops after 4th acc, cm_count=4, 5th held; raise cm_ready -> 5th accepted same cycle as pop, count stays 4.
REQ-020 Order/wrap: push 10 groups with pc 0x100..0x124 step 4, random cm_ready -> cm_pc pops in exact order, no loss, pointers wrap twice.
REQ-021 Reset mid-stream: 3 groups queued, rst low 1 cycle -> wb_en=0, cm_valid=0, cm_count=0 immediately; after release new group pops first.
